// File: rtl/video_clk_pkg.sv
// Shared constants and types for the video clock-enable DDS.
// Increment constants assume a 50 MHz reference and a 32-bit accumulator.
package video_clk_pkg;

    localparam int ACC_W_DEFAULT = 32;

    localparam logic [31:0] INC_25M_AT_50M  = 32'h80000000;
    localparam logic [31:0] INC_40M_AT_50M  = 32'hCCCCCCCD;
    localparam logic [31:0] INC_33M3_AT_50M = 32'hAAAAAAAB;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/dds_chan.sv
// One DDS phase accumulator: the carry out of the adder marks one output period.
// The clear input restarts the phase at zero on the same edge.
module dds_chan
    import video_clk_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic [ACC_W-1:0] inc,
    input  logic             clear,
    output logic             carry
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sum;

    assign sum   = {1'b0, acc_q} + {1'b0, inc};
    assign carry = sum[ACC_W];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else begin
            acc_q <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/video_clken_dds.sv
// NUM_CLOCKS fractional-rate clock-enable generators with a runtime config port.
// Optional macro VIDEO_CLKEN_PHASE_ALIGN_EN: every accepted config restarts all phases at zero.
//
// state  | meaning
// SETTLE | counting LOCK_CYCLES after reset or a config accept; enables held low
// LOCKED | all channels running; one config request may be accepted
module video_clken_dds
    import video_clk_pkg::*;
#(
    parameter int NUM_CLOCKS  = 3,
    parameter int ACC_W       = ACC_W_DEFAULT,
    parameter int LOCK_CYCLES = 16,
    parameter logic [NUM_CLOCKS*ACC_W-1:0] INC_DEFAULT =
        {INC_33M3_AT_50M, INC_40M_AT_50M, INC_25M_AT_50M},
    localparam int CW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CW-1:0]         cfg_chan,
    input  logic [ACC_W-1:0]      cfg_inc,
    output logic                  cfg_err,
    output logic [NUM_CLOCKS-1:0] clk_en,
    output logic                  locked
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  locked_q;
    logic                  cfg_err_q;
    logic [NUM_CLOCKS-1:0] clk_en_q;
    logic [ACC_W-1:0]      inc_q [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] carry;

    logic handshake;
    logic chan_ok;
    logic accept_ok;
    logic locked_next;
    logic align_clr;

    assign cfg_ready = locked_q;
    assign locked    = locked_q;
    assign cfg_err   = cfg_err_q;
    assign clk_en    = clk_en_q;

    assign handshake = cfg_valid & locked_q;
    assign chan_ok   = ({{(32-CW){1'b0}}, cfg_chan} < 32'(NUM_CLOCKS));
    assign accept_ok = handshake & chan_ok;

`ifdef VIDEO_CLKEN_PHASE_ALIGN_EN
    assign align_clr = accept_ok;
`else
    assign align_clr = 1'b0;
`endif

    // Enables use the post-edge lock state so a carry on the accepting edge is dropped.
    always_comb begin
        locked_next = locked_q;
        case (state_q)
            SETTLE:  locked_next = (cnt_q == CNT_LAST);
            LOCKED:  locked_next = ~accept_ok;
            default: locked_next = 1'b0;
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= SETTLE;
            cnt_q     <= '0;
            locked_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            clk_en_q  <= '0;
        end else begin
            locked_q  <= locked_next;
            cfg_err_q <= handshake & ~chan_ok;
            clk_en_q  <= carry & {NUM_CLOCKS{locked_next}};
            case (state_q)
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= LOCKED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (accept_ok) begin
                        state_q <= SETTLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= SETTLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                inc_q[i] <= INC_DEFAULT[i*ACC_W +: ACC_W];
            end
        end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                if (accept_ok && (cfg_chan == CW'(i))) begin
                    inc_q[i] <= cfg_inc;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
        dds_chan #(
            .ACC_W (ACC_W)
        ) u_chan (
            .refclk (refclk),
            .rst    (rst),
            .inc    (inc_q[g]),
            .clear  (align_clr),
            .carry  (carry[g])
        );
    end

endmodule

// File: doc/video_clken_dds.md
Name: video_clken_dds

Overview:
- Parametrised successor to the fixed three-output video PLL wrapper.
- Generates NUM_CLOCKS independent fractional-rate clock-enable pulse trains from one reference clock, using per-channel DDS phase accumulators.
- Per-channel rates are runtime-reprogrammable through a valid/ready config port; a locked indication reflects settle state after reset or reconfiguration.
- Sits between the board reference clock and the pixel/timing logic, so video modes (25 / 40 / 33.333 MHz equivalents) switch without a new PLL.

Parameters:
- NUM_CLOCKS, 3, number of enable channels (1..16).
- ACC_W, 32, phase accumulator and increment width in bits.
- LOCK_CYCLES, 16, refclk cycles from reset release or config accept until locked asserts (>=1).
- INC_DEFAULT, {32'hAAAAAAAB, 32'hCCCCCCCD, 32'h80000000}, packed NUM_CLOCKS*ACC_W reset increments; channel 0 is the LSB slice. At 50 MHz these give 25, 40 and 33.333 MHz.

Ports:
- refclk  in  1  reference clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted; equals locked.
- cfg_chan  in  CW=max(1,$clog2(NUM_CLOCKS))  target channel.
- cfg_inc  in  ACC_W  new phase increment.
- cfg_err  out  1  one-cycle pulse when an accepted cfg_chan >= NUM_CLOCKS.
- clk_en  out  NUM_CLOCKS  per-channel enable pulses, registered.
- locked  out  1  all channels running at their programmed rates.

Behaviour:
- Reset (async):
  - acc[i]=0, inc[i]=INC_DEFAULT slice i.
  - clk_en=0, locked=0, cfg_err=0, cnt=0, state=SETTLE.
- Accumulator, every cycle for each i:
  - {carry,acc[i]} <= acc[i] + inc[i], computed ACC_W+1 wide; the accumulator wraps modulo 2^ACC_W.
  - clk_en[i] <= carry & locked_next, registered. This is 1-cycle latency from the wrap.
  - Enables are forced to 0 while not locked, but the accumulators keep running.
- Average pulse rate is f_ref*inc/2^ACC_W.
  - inc=0 means a silent channel.
  - inc=2^31 (ACC_W=32) pulses every 2nd cycle.
- FSM, two states:
  - SETTLE: cnt increments each cycle. When cnt==LOCK_CYCLES-1: state<=LOCKED, locked<=1, cnt<=0. locked therefore rises on the LOCK_CYCLES-th edge after reset release or accept.
  - LOCKED: holds. A handshake (cfg_valid & cfg_ready) with a valid channel sets inc[cfg_chan]<=cfg_inc, locked<=0, cnt<=0, state<=SETTLE, all on the accepting edge.
- Handshake:
  - cfg_ready = locked (combinational from the register). Requests during SETTLE wait; the master holds cfg_valid and the data stable.
  - Only one config is accepted per settle period.
- Invalid channel (accepted with cfg_chan >= NUM_CLOCKS):
  - cfg_err pulses 1 cycle.
  - No inc change, locked stays 1, state stays LOCKED.
- Reset mid-settle or mid-operation: immediate return to reset values, including the default increments. Programmed increments are lost.
- An accept and a channel carry on the same edge: the new inc applies from the next addition. That carry's enable is suppressed because locked_next=0.

Optional Feature:
- Macro: VIDEO_CLKEN_PHASE_ALIGN_EN.
- Defined: every valid config accept also clears all acc[i] to 0 on the accepting edge, so all channels restart phase-aligned.
- Not defined: accumulators keep their current values; only inc[cfg_chan] changes.

Decomposition:
- Package video_clk_pkg holds:
  - ACC_W_DEFAULT.
  - Named increment constants: INC_25M_AT_50M=32'h80000000, INC_40M_AT_50M=32'hCCCCCCCD, INC_33M3_AT_50M=32'hAAAAAAAB.
  - State enum {SETTLE, LOCKED}.
- Sub-module dds_chan, generated NUM_CLOCKS times: acc register, adder, carry output, align-clear input.
- FSM and lock counter live in the top.

Test Plan:
1. Reset release with defaults, ACC_W=32, LOCK_CYCLES=16 -> locked=0 for edges 1..15 and 1 from edge 16. clk_en[0] then pulses every 2nd cycle, exactly 100 pulses per 200 cycles. clk_en[1] gives 160 per 200 cycles ±1; clk_en[2] gives 133 per 200 cycles ±1.
2. While locked, write cfg_chan=0, cfg_inc=32'h40000000 -> cfg_ready and locked drop the next cycle. clk_en is all 0 for 16 cycles, then clk_en[0] pulses every 4th cycle and the other channels are unchanged.
3. cfg_valid held during SETTLE -> no accept until locked=1. Accept happens on the first locked cycle; exactly one inc update occurs.
4. cfg_chan=3 with NUM_CLOCKS=3 -> cfg_err is a 1-cycle pulse, locked stays 1, all rates unchanged.
5. Assert rst 5 cycles into SETTLE after a reconfig -> outputs go 0 immediately. After release, default rates and a 16-cycle lock reappear.
6. With VIDEO_CLKEN_PHASE_ALIGN_EN and channels 0 and 1 both programmed to 32'h80000000 -> after lock, clk_en[0]==clk_en[1] every cycle. Without the macro, the relative phase is preserved from before the write.
